spmv_nnz_extractor: RTL and testbench



---
 rtl/spmv_nnz_extractor.sv | 163 ++++++++++++++++
 tb/tb_spmv_nnz_extractor.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_nnz_extractor.sv
// Dense-row to nonzero-stream compressor feeding the SpMV multiply core.
// One SRAM0 word per row; each row becomes nonzero beats or one empty marker.
module spmv_nnz_extractor #(
    parameter int DATA_LEN        = 32,
    parameter int N               = 8,
    parameter int M               = 8,
    parameter int ADDRESS_SIZE    = 4,
    parameter int ROW_ADDR_OFFSET = 8,
    parameter int COL_W           = (N > 1) ? $clog2(N) : 1,
    parameter int ROW_W           = (M > 1) ? $clog2(M) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    output logic [ADDRESS_SIZE-1:0] o_address_A,
    output logic                    o_wr_en_A,
    input  logic [DATA_LEN*N-1:0]   i_read_data_A,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_LEN-1:0]     o_value,
    output logic [COL_W-1:0]        o_col,
    output logic [ROW_W-1:0]        o_row,
    output logic                    o_last,
    output logic                    o_empty,
    output logic [15:0]             o_nnz_count,
    output logic                    o_busy,
    output logic                    o_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAT,
        S_LOAD,
        S_EMIT,
        S_DONE
    } state_t;

    localparam logic [ADDRESS_SIZE-1:0] ADDR_BASE = ADDRESS_SIZE'(ROW_ADDR_OFFSET);
    localparam logic [ROW_W-1:0]        ROW_LAST  = ROW_W'(M - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ROW_W-1:0]          r_row;
    logic [ADDRESS_SIZE-1:0]   r_addr;
    logic [DATA_LEN*N-1:0]     r_buf;
    logic [N-1:0]              r_mask;
    logic [15:0]               r_nnz;

    logic [N-1:0]              w_mask_in;
    logic [COL_W-1:0]          w_sel;
    logic                      w_has;
    logic                      w_single;
    logic                      w_last_beat;
    logic                      w_emit;
    logic                      w_fire;
    logic                      w_final_row;

    // Bitwise compare, so IEEE -0.0 (sign bit only) is kept as a nonzero.
    always_comb begin
        w_mask_in = '0;
        for (int j = 0; j < N; j++) begin
            w_mask_in[j] = |i_read_data_A[DATA_LEN*j +: DATA_LEN];
        end
    end

    always_comb begin
        w_sel = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (r_mask[j]) begin
                w_sel = COL_W'(j);
            end
        end
    end

    assign w_has       = |r_mask;
    assign w_single    = w_has && ((r_mask & (r_mask - N'(1))) == '0);
    assign w_last_beat = !w_has || w_single;
    assign w_emit      = (r_state == S_EMIT);
    assign w_fire      = w_emit && i_ready;
    assign w_final_row = (r_row == ROW_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_LAT;
            S_LAT:   w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (w_fire && w_last_beat) begin
                    w_state_nxt = w_final_row ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_row  <= '0;
            r_addr <= ADDR_BASE;
            r_buf  <= '0;
            r_mask <= '0;
            r_nnz  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row  <= '0;
                        r_addr <= ADDR_BASE;
                        r_nnz  <= '0;
                    end
                end
                S_LOAD: begin
                    r_buf  <= i_read_data_A;
                    r_mask <= w_mask_in;
                end
                S_EMIT: begin
                    if (w_fire) begin
                        if (w_has) begin
                            r_mask <= r_mask & ~(N'(1) << w_sel);
                            r_nnz  <= r_nnz + 16'd1;
                        end
                        // Address never steps past the final row's word.
                        if (w_last_beat && !w_final_row) begin
                            r_row  <= r_row + ROW_W'(1);
                            r_addr <= r_addr + ADDRESS_SIZE'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_address_A = r_addr;
    assign o_wr_en_A   = 1'b0;
    assign o_valid     = w_emit;
    assign o_value     = (w_emit && w_has) ? r_buf[DATA_LEN*w_sel +: DATA_LEN] : '0;
    assign o_col       = (w_emit && w_has) ? w_sel : '0;
    assign o_row       = w_emit ? r_row : '0;
    assign o_last      = w_emit && w_last_beat;
    assign o_empty     = w_emit && !w_has;
    assign o_nnz_count = r_nnz;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_spmv_nnz_extractor.sv
// Scoreboard bench for spmv_nnz_extractor: model beats from a memory image,
// compare every presented beat, plus timing, stall, reset and restart cases.
module tb_spmv_nnz_extractor;

    localparam int DL  = 32;
    localparam int N   = 8;
    localparam int M   = 8;
    localparam int AW  = 4;
    localparam int OFF = 8;

    typedef struct packed {
        logic [DL-1:0] v;
        logic [2:0]    c;
        logic [2:0]    r;
        logic          l;
        logic          e;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW-1:0]   addr;
    logic            wr_en;
    logic [DL*N-1:0] rdata;
    logic            valid;
    logic            ready;
    logic [DL-1:0]   value;
    logic [2:0]      col;
    logic [2:0]      row;
    logic            last;
    logic            empty;
    logic [15:0]     nnz;
    logic            busy;
    logic            done;

    logic [DL*N-1:0] mem [0:15];
    beat_t           sb[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t_busy, t_first, t_done;
    int done_cnt, stall_cnt, exp_nnz;
    bit busy_q, seen_valid;

    spmv_nnz_extractor #(
        .DATA_LEN(DL), .N(N), .M(M), .ADDRESS_SIZE(AW), .ROW_ADDR_OFFSET(OFF)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_address_A(addr), .o_wr_en_A(wr_en), .i_read_data_A(rdata),
        .o_valid(valid), .i_ready(ready), .o_value(value), .o_col(col),
        .o_row(row), .o_last(last), .o_empty(empty), .o_nnz_count(nnz),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdata = mem[addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 16; a++) mem[a] = '0;
    endtask

    task automatic set_lane(input int r, input int j, input logic [DL-1:0] v);
        mem[OFF+r][DL*j +: DL] = v;
    endtask

    task automatic build_expected();
        logic [DL-1:0] v;
        int            cnt, seen;
        beat_t         b;
        exp_nnz = 0;
        for (int r = 0; r < M; r++) begin
            cnt = 0;
            for (int j = 0; j < N; j++) if (mem[OFF+r][DL*j +: DL] != 0) cnt++;
            if (cnt == 0) begin
                b = '{v: '0, c: 3'd0, r: 3'(r), l: 1'b1, e: 1'b1};
                sb.push_back(b);
            end else begin
                seen = 0;
                for (int j = 0; j < N; j++) begin
                    v = mem[OFF+r][DL*j +: DL];
                    if (v != 0) begin
                        seen++;
                        b = '{v: v, c: 3'(j), r: 3'(r), l: (seen == cnt), e: 1'b0};
                        sb.push_back(b);
                        exp_nnz++;
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (busy && !busy_q) t_busy = cyc;
            busy_q = busy;
            if (valid && !seen_valid) begin
                t_first    = cyc;
                seen_valid = 1'b1;
            end
            if (done) begin
                t_done = cyc;
                done_cnt++;
            end
            if (valid) begin
                if (sb.size() == 0) begin
                    chk("extra_beat", 64'd1, 64'd0);
                end else begin
                    b = sb[0];
                    chk("value", 64'(value), 64'(b.v));
                    chk("col", 64'(col), 64'(b.c));
                    chk("row", 64'(row), 64'(b.r));
                    chk("last", 64'(last), 64'(b.l));
                    chk("empty", 64'(empty), 64'(b.e));
                    if (!ready) stall_cnt++;
                    else void'(sb.pop_front());
                end
            end
        end
    end

    // mode 0: ready=1; 1: stall 5 cycles on first row-2 beat; 2: start pulse in row 1
    task automatic run(input int mode, input bit timing, input int span);
        bit stalled, pulsed;
        int hold, k;
        build_expected();
        done_cnt   = 0;
        stall_cnt  = 0;
        seen_valid = 1'b0;
        busy_q     = 1'b0;
        stalled    = 1'b0;
        pulsed     = 1'b0;
        hold       = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (done_cnt == 0 && k < 1000) begin
            @(posedge clk); #1;
            k++;
            if (start) start = 1'b0;
            if (hold > 0) begin
                hold--;
                if (hold == 0) ready = 1'b1;
            end
            if (mode == 1 && !stalled && valid && row == 3'd2) begin
                ready   = 1'b0;
                hold    = 5;
                stalled = 1'b1;
            end
            if (mode == 2 && !pulsed && valid && row == 3'd1) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end
        end
        if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("nnz_count", 64'(nnz), 64'(exp_nnz));
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        if (timing) begin
            chk("done_span", 64'(t_done - t_busy), 64'(span));
            chk("first_lat", 64'(t_first - t_busy), 64'd3);
        end
        if (mode == 1) chk("stall_cycles", 64'(stall_cnt), 64'd5);
        sb.delete();
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 64'(addr), 64'(OFF));
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_nnz", 64'(nnz), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < M; r++) set_lane(r, r, 32'd1);
        run(0, 1'b1, 32);

        clear_mem();
        run(0, 1'b1, 32);

        clear_mem();
        for (int j = 0; j < N; j++) set_lane(0, j, 32'(j + 1));
        run(0, 1'b1, 39);

        clear_mem();
        set_lane(2, 3, 32'h8000_0000);
        set_lane(2, 6, 32'hDEAD_BEEF);
        run(1, 1'b0, 0);

        clear_mem();
        for (int r = 0; r < M; r++) set_lane(r, r, 32'(r + 7));
        build_expected();
        busy_q = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (!(valid && row == 3'd4) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("reach_row4", 64'(valid && row == 3'd4), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_value", 64'(value), 64'd0);
        chk("mid_rst_rowlast", 64'({row, last, empty}), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_nnz", 64'(nnz), 64'd0);
        chk("mid_rst_addr", 64'(addr), 64'(OFF));
        @(posedge clk); #1 rst = 1'b0;
        sb.delete();
        run(0, 1'b1, 32);

        run(2, 1'b1, 32);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
